// File: rtl/sccb_master_if.sv
// SCCB master bundle: request/response handshake plus the 3-wire pad signals.
// The master modport is the transmitter's view, slave is the sequencer/pad side.
interface sccb_master_if;
    logic       sccb_start;
    logic [7:0] sccb_addr;
    logic [7:0] sccb_data;
    logic       sccb_done;
    logic       sccb_busy;
    logic       sccb_nack;
    logic       sio_c;
    logic       sio_d_out;
    logic       sio_d_oe;
    logic       sio_d_in;

    modport master (
        input  sccb_start, sccb_addr, sccb_data, sio_d_in,
        output sccb_done, sccb_busy, sccb_nack, sio_c, sio_d_out, sio_d_oe
    );

    modport slave (
        output sccb_start, sccb_addr, sccb_data, sio_d_in,
        input  sccb_done, sccb_busy, sccb_nack, sio_c, sio_d_out, sio_d_oe
    );
endinterface

// File: rtl/sccb_master.sv
// SCCB 3-phase write transmitter (device ID, sub-address, data).
// Each bit is four quarter periods of DIV clocks; SIO_C is low for Q0-Q1 and
// high for Q2-Q3, so SIO_D only moves while the clock is low.
// Optional macro SCCB_ACK_CHECK_EN: sample SIO_D during the don't-care bits and
// report a sticky per-transaction NACK; otherwise sccb_nack stays 0.
module sccb_master #(
    parameter int         CLK_FREQ_HZ  = 100_000_000,
    parameter int         SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0] DEV_ID       = 8'h42
) (
    input  logic          clk,
    input  logic          rst_n,
    sccb_master_if.master bus
);
    // Quarter-bit divider; DIV must come out >= 1 for the chosen frequencies.
    localparam int DIV = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_DC, S_STOP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          nack_q, nack_d;

    logic          qtick;
    logic [7:0]    cur_byte;
    logic          sio_c, sio_d_out, sio_d_oe, busy, done;

    assign qtick    = (cnt_q == CW'(DIV - 1));
    assign cur_byte = (byte_q == 2'd0) ? DEV_ID :
                      (byte_q == 2'd1) ? addr_q : data_q;

`ifndef SCCB_ACK_CHECK_EN
    // Pad readback has no use without the ACK check.
    logic unused_sio_d_in;
    assign unused_sio_d_in = bus.sio_d_in;
`endif

    // State, counters and latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= 3'd7;
            byte_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
        end
    end

    // Next-state sequencing and line drive decoded from state and quarter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = qtick ? '0 : cnt_q + CW'(1);
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        addr_d    = addr_q;
        data_d    = data_q;
        nack_d    = nack_q;
        sio_c     = 1'b1;
        sio_d_out = 1'b1;
        sio_d_oe  = 1'b1;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.sccb_start) begin
                    addr_d  = bus.sccb_addr;
                    data_d  = bus.sccb_data;
                    cnt_d   = '0;
                    qtr_d   = '0;
                    bit_d   = 3'd7;
                    byte_d  = '0;
                    nack_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // Data falls in Q2 with the clock still high, clock falls in Q3.
                sio_c     = (qtr_q != 2'd3);
                sio_d_out = (qtr_q < 2'd2);
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        bit_d   = 3'd7;
                        byte_d  = '0;
                        state_d = S_BIT;
                    end
                end
            end
            S_BIT: begin
                sio_c     = qtr_q[1];
                sio_d_out = cur_byte[bit_q];
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 3'd0) state_d = S_DC;
                        else               bit_d   = bit_q - 3'd1;
                    end
                end
            end
            S_DC: begin
                sio_c    = qtr_q[1];
                sio_d_oe = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
                if (qtick && qtr_q == 2'd2 && bus.sio_d_in) nack_d = 1'b1;
`endif
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (byte_q < 2'd2) begin
                            byte_d  = byte_q + 2'd1;
                            bit_d   = 3'd7;
                            state_d = S_BIT;
                        end else begin
                            state_d = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                // Clock rises in Q1 with data low, data rises in Q2.
                sio_c     = (qtr_q != 2'd0);
                sio_d_out = qtr_q[1];
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.sio_c     = sio_c;
    assign bus.sio_d_out = sio_d_out;
    assign bus.sio_d_oe  = sio_d_oe;
    assign bus.sccb_busy = busy;
    assign bus.sccb_done = done;
    assign bus.sccb_nack = nack_q;
endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: decodes SIO_C/SIO_D into frames, watches START/STOP
// ordering, and compares against frames and timings computed from the
// protocol rules (3 bytes x 9 bits, 116 quarters per write).
module tb_sccb_master;
    localparam int         CLK_HZ  = 4_000_000;
    localparam int         SCCB_HZ = 100_000;
    localparam int         DIV     = CLK_HZ / (4 * SCCB_HZ);
    localparam logic [7:0] DEVID   = 8'h42;
    localparam int         EXP_LAT  = 116 * DIV + 1;
    localparam int         EXP_BUSY = 116 * DIV;
`ifdef SCCB_ACK_CHECK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sccb_master_if bus ();

    sccb_master #(.CLK_FREQ_HZ(CLK_HZ), .SCCB_FREQ_HZ(SCCB_HZ), .DEV_ID(DEVID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Bus monitor: bit capture on SIO_C rising edges, protocol event counts.
    logic [1:0] rise_q[$];
    int   falls = 0, rises = 0, dones = 0, busys = 0;
    logic prev_c = 1'b1, prev_d = 1'b1;
    always @(negedge clk) begin
        if (prev_c && bus.sio_c && prev_d && !bus.sio_d_out) falls <= falls + 1;
        if (prev_c && bus.sio_c && !prev_d && bus.sio_d_out) rises <= rises + 1;
        if (!prev_c && bus.sio_c) rise_q.push_back({bus.sio_d_oe, bus.sio_d_out});
        if (bus.sccb_done) dones <= dones + 1;
        if (bus.sccb_busy) busys <= busys + 1;
        prev_c <= bus.sio_c;
        prev_d <= bus.sio_d_out;
    end

    // One write; din_mode 0: sio_d_in low, 1: high across 2nd DC bit, 2: always high.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit inject,
                            input int din_mode, output int lat, output logic [23:0] frame,
                            output logic [2:0] dc_oe, output logic nack_early,
                            output logic nack_done);
        falls = 0; rises = 0; dones = 0; busys = 0;
        rise_q.delete();
        lat = -1; frame = 'x; dc_oe = 'x; nack_early = 1'bx; nack_done = 1'bx;
        @(negedge clk);
        bus.sccb_start = 1'b1; bus.sccb_addr = a; bus.sccb_data = d;
        bus.sio_d_in = (din_mode == 2);
        @(posedge clk); #1;
        bus.sccb_start = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n == 1) nack_early = bus.sccb_nack;
            if (din_mode == 1) bus.sio_d_in = (n > 72 * DIV && n <= 76 * DIV);
            if (inject) begin
                bus.sccb_start = (n == 50 || n == 600);
                if (n == 50) begin bus.sccb_addr = 8'hFF; bus.sccb_data = 8'hFF; end
            end
            if (bus.sccb_done) begin lat = n; nack_done = bus.sccb_nack; break; end
        end
        bus.sccb_start = 1'b0; bus.sio_d_in = 1'b0;
        #1;
        if (rise_q.size() == 28) begin
            for (int i = 0; i < 27; i++) begin
                if (i % 9 < 8) frame[23 - 8 * (i / 9) - (i % 9)] = rise_q[i][0];
                else           dc_oe[i / 9] = rise_q[i][1];
            end
        end
    endtask

    task automatic test_reset();
        bus.sccb_start = 1'b0; bus.sccb_addr = '0; bus.sccb_data = '0; bus.sio_d_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.sio_c, bus.sio_d_out, bus.sio_d_oe, bus.sccb_busy, bus.sccb_done, bus.sccb_nack} !== 6'b111000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=111000",
                {bus.sio_c, bus.sio_d_out, bus.sio_d_oe, bus.sccb_busy, bus.sccb_done, bus.sccb_nack});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.sio_c, bus.sio_d_out, bus.sccb_busy} !== 3'b110) begin
            bad++; $display("FAIL idle_after_reset got=%b exp=110", {bus.sio_c, bus.sio_d_out, bus.sccb_busy});
        end
    endtask

    task automatic test_single();
        int lat; logic [23:0] fr; logic [2:0] oe; logic ne, nd;
        do_write(8'h12, 8'h04, 1'b0, 0, lat, fr, oe, ne, nd);
        total++; if (fr !== {DEVID, 8'h12, 8'h04}) begin bad++; $display("FAIL single_frame got=%h exp=%h", fr, {DEVID, 8'h12, 8'h04}); end
        total++; if (oe !== 3'b000) begin bad++; $display("FAIL single_dc_oe got=%b exp=000", oe); end
        total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, EXP_LAT); end
        total++; if (busys !== EXP_BUSY) begin bad++; $display("FAIL single_busy_cycles got=%0d exp=%0d", busys, EXP_BUSY); end
        total++; if (dones !== 1) begin bad++; $display("FAIL single_done_pulses got=%0d exp=1", dones); end
        total++; if (falls !== 1) begin bad++; $display("FAIL start_cond got=%0d exp=1", falls); end
        total++; if (rises !== 1) begin bad++; $display("FAIL stop_cond got=%0d exp=1", rises); end
        @(negedge clk);
        total++;
        if ({bus.sio_c, bus.sio_d_out, bus.sio_d_oe, bus.sccb_busy, bus.sccb_done} !== 5'b11100) begin
            bad++; $display("FAIL idle_bus got=%b exp=11100",
                {bus.sio_c, bus.sio_d_out, bus.sio_d_oe, bus.sccb_busy, bus.sccb_done});
        end
    endtask

    task automatic test_random();
        int lat; logic [23:0] fr; logic [2:0] oe; logic ne, nd;
        logic [7:0] a, d;
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom); d = 8'($urandom);
            do_write(a, d, 1'b0, 0, lat, fr, oe, ne, nd);
            total++; if (fr !== {DEVID, a, d}) begin bad++; $display("FAIL rand_frame%0d got=%h exp=%h", k, fr, {DEVID, a, d}); end
            total++; if (lat !== EXP_LAT || oe !== 3'b000) begin bad++; $display("FAIL rand_timing%0d got=%0d/%b exp=%0d/000", k, lat, oe, EXP_LAT); end
            total++; if (falls !== 1 || rises !== 1) begin bad++; $display("FAIL rand_protocol%0d got=%0d/%0d exp=1/1", k, falls, rises); end
        end
    endtask

    task automatic test_ignore_start();
        int lat; logic [23:0] fr; logic [2:0] oe; logic ne, nd;
        logic [7:0] a, d;
        a = 8'($urandom_range(0, 254)); d = 8'($urandom);
        do_write(a, d, 1'b1, 0, lat, fr, oe, ne, nd);
        total++; if (fr !== {DEVID, a, d}) begin bad++; $display("FAIL ignore_frame got=%h exp=%h", fr, {DEVID, a, d}); end
        total++; if (dones !== 1 || lat !== EXP_LAT) begin bad++; $display("FAIL ignore_done got=%0d/%0d exp=1/%0d", dones, lat, EXP_LAT); end
        repeat (3) @(negedge clk);
        total++; if (bus.sccb_busy !== 1'b0) begin bad++; $display("FAIL ignore_no_requeue got=%b exp=0", bus.sccb_busy); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [23:0] fr; logic [2:0] oe; logic ne, nd;
        logic [15:0] seq [3];
        int done_sum = 0;
        seq[0] = 16'h1204; seq[1] = 16'h8C02; seq[2] = 16'h40D0;
        for (int k = 0; k < 3; k++) begin
            do_write(seq[k][15:8], seq[k][7:0], 1'b0, 0, lat, fr, oe, ne, nd);
            done_sum += dones;
            total++; if (fr !== {DEVID, seq[k]}) begin bad++; $display("FAIL b2b_frame%0d got=%h exp=%h", k, fr, {DEVID, seq[k]}); end
            total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL b2b_latency%0d got=%0d exp=%0d", k, lat, EXP_LAT); end
        end
        total++; if (done_sum !== 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", done_sum); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [23:0] fr; logic [2:0] oe; logic ne, nd;
        int cut;
        // Byte 1 occupies quarters 40..75 of the frame.
        cut = 45 * DIV + int'($urandom_range(0, 25 * DIV));
        @(negedge clk);
        bus.sccb_start = 1'b1; bus.sccb_addr = 8'h5A; bus.sccb_data = 8'hA5;
        @(posedge clk); #1;
        bus.sccb_start = 1'b0;
        repeat (cut) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.sio_c, bus.sio_d_out, bus.sio_d_oe, bus.sccb_busy, bus.sccb_done, bus.sccb_nack} !== 6'b111000) begin
            bad++; $display("FAIL midreset_outputs got=%b exp=111000",
                {bus.sio_c, bus.sio_d_out, bus.sio_d_oe, bus.sccb_busy, bus.sccb_done, bus.sccb_nack});
        end
        dones = 0;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total++; if (dones !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
        do_write(8'h12, 8'h80, 1'b0, 0, lat, fr, oe, ne, nd);
        total++; if (fr !== {DEVID, 8'h12, 8'h80}) begin bad++; $display("FAIL postreset_frame got=%h exp=%h", fr, {DEVID, 8'h12, 8'h80}); end
        total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL postreset_latency got=%0d exp=%0d", lat, EXP_LAT); end
    endtask

    task automatic test_nack();
        int lat; logic [23:0] fr; logic [2:0] oe; logic ne, nd;
        int modes [4];
        logic exp;
        modes[0] = 0; modes[1] = 1; modes[2] = 0; modes[3] = 2;
        for (int k = 0; k < 4; k++) begin
            do_write(8'($urandom), 8'($urandom), 1'b0, modes[k], lat, fr, oe, ne, nd);
            exp = ACK_EN && (modes[k] != 0);
            total++; if (nd !== exp) begin bad++; $display("FAIL nack_done%0d got=%b exp=%b", k, nd, exp); end
            total++; if (ne !== 1'b0) begin bad++; $display("FAIL nack_clear_on_accept%0d got=%b exp=0", k, ne); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_nack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
